// File: rtl/pagerank_pkg.sv
// Shared types and helpers for the PageRank pipeline stages.
// Ranks are Q32.32 fixed point held in 64-bit words.
package pagerank_pkg;

  typedef logic [63:0] rank_t;
  typedef logic [31:0] node_id_t;

  typedef enum logic [1:0] {
    G_IDLE,
    G_ACCUM,
    G_APPLY,
    G_DONE
  } gather_state_t;

  localparam rank_t RANK_MAX = 64'hFFFF_FFFF_FFFF_FFFF;

  function automatic rank_t sat_add64(input rank_t a, input rank_t b);
    logic [64:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[64] ? RANK_MAX : sum[63:0];
  endfunction

endpackage

// File: rtl/pagerank_damp_mul.sv
// Combinational damping stage: rank = sat(acc * d >> 32) + teleport, saturating.
// acc is Q32.32, d is Q0.32; the result stays Q32.32.
module pagerank_damp_mul
  import pagerank_pkg::*;
#(
  parameter logic [31:0] DAMPING_Q32  = 32'hD999_9999,
  parameter rank_t       TELEPORT_Q32 = 64'h0000_0000_0999_9999
) (
  input  rank_t acc,
  output rank_t damped,
  output rank_t rank
);

  logic [127:0] prod;
  logic [31:0]  prod_hi;
  logic [63:0]  prod_mid;
  logic [31:0]  unused_frac;

  assign prod = 128'(acc) * 128'(DAMPING_Q32);
  assign {prod_hi, prod_mid, unused_frac} = prod;

  // A 64x32 product never reaches past bit 95, so the guard only clamps a
  // result that would not fit in 64 bits after dropping the Q0.32 fraction.
  assign damped = (|prod_hi) ? RANK_MAX : prod_mid;
  assign rank   = sat_add64(damped, TELEPORT_Q32);

endmodule

// File: rtl/pagerank_gather.sv
// Gather phase of a PageRank iteration: accumulate scatter contributions per node,
// then stream damped + teleport ranks. Optional convergence check: PAGERANK_GATHER_CONV_EN.
module pagerank_gather
  import pagerank_pkg::*;
#(
  parameter int          NODES_IN_PARTITION = 4,
  parameter node_id_t    NODE_ID_BASE       = 32'd0,
  parameter logic [31:0] DAMPING_Q32        = 32'hD999_9999,
  parameter rank_t       TELEPORT_Q32       = 64'h0000_0000_0999_9999,
  parameter rank_t       CONV_THRESH        = 64'h0000_0000_0010_0000
) (
  input  logic                                clock,
  input  logic                                reset,
  input  logic                                start,
  input  logic                                contrib_valid,
  input  rank_t                               contrib_value,
  input  node_id_t                            contrib_node_id,
  input  logic                                scatter_done,
  input  rank_t [NODES_IN_PARTITION-1:0]      page_rank_old,
  output logic                                rank_valid,
  output node_id_t                            rank_node_id,
  output rank_t                               rank_value,
  output logic                                gather_complete,
  output logic                                busy,
  output logic [15:0]                         drop_count,
  output logic                                converged
);

  localparam int IDX_W = (NODES_IN_PARTITION > 1) ? $clog2(NODES_IN_PARTITION) : 1;
  localparam logic [IDX_W-1:0] LAST_K = IDX_W'(NODES_IN_PARTITION - 1);

  gather_state_t    state;
  rank_t            acc [NODES_IN_PARTITION];
  logic [IDX_W-1:0] k;
  node_id_t         idx;
  logic             idx_hit;
  logic             start_accept;
  rank_t            apply_damped;
  rank_t            apply_rank;

  // Unsigned subtract makes IDs below the base wrap high and fall out of range.
  assign idx          = contrib_node_id - NODE_ID_BASE;
  assign idx_hit      = idx < node_id_t'(NODES_IN_PARTITION);
  assign start_accept = start && (state == G_IDLE || state == G_ACCUM);
  assign busy         = (state != G_IDLE);

  pagerank_damp_mul #(
    .DAMPING_Q32 (DAMPING_Q32),
    .TELEPORT_Q32(TELEPORT_Q32)
  ) u_damp (
    .acc   (acc[k]),
    .damped(apply_damped),
    .rank  (apply_rank)
  );

  logic unused_damped;
  assign unused_damped = ^apply_damped;

  always_ff @(posedge clock) begin
    if (reset) begin
      state           <= G_IDLE;
      k               <= '0;
      rank_valid      <= 1'b0;
      rank_node_id    <= '0;
      rank_value      <= '0;
      gather_complete <= 1'b0;
      drop_count      <= '0;
      for (int i = 0; i < NODES_IN_PARTITION; i++) acc[i] <= '0;
    end else begin
      rank_valid      <= 1'b0;
      gather_complete <= 1'b0;
      unique case (state)
        G_IDLE: begin
          if (start) begin
            state      <= G_ACCUM;
            k          <= '0;
            drop_count <= '0;
            for (int i = 0; i < NODES_IN_PARTITION; i++) acc[i] <= '0;
          end
        end
        G_ACCUM: begin
          // A restart wins over both a pending contribution and scatter_done.
          if (start) begin
            k          <= '0;
            drop_count <= '0;
            for (int i = 0; i < NODES_IN_PARTITION; i++) acc[i] <= '0;
          end else begin
            if (contrib_valid) begin
              if (idx_hit)
                acc[idx[IDX_W-1:0]] <= sat_add64(acc[idx[IDX_W-1:0]], contrib_value);
              else if (drop_count != 16'hFFFF)
                drop_count <= drop_count + 16'd1;
            end
            if (scatter_done) begin
              state <= G_APPLY;
              k     <= '0;
            end
          end
        end
        G_APPLY: begin
          rank_valid   <= 1'b1;
          rank_value   <= apply_rank;
          rank_node_id <= NODE_ID_BASE + node_id_t'(k);
          if (k == LAST_K) state <= G_DONE;
          else             k     <= k + IDX_W'(1);
        end
        G_DONE: begin
          gather_complete <= 1'b1;
          state           <= G_IDLE;
        end
        default: state <= G_IDLE;
      endcase
    end
  end

`ifdef PAGERANK_GATHER_CONV_EN
  rank_t old_k;
  rank_t delta;
  rank_t delta_sum;
  rank_t delta_sum_next;

  assign old_k          = page_rank_old[k];
  assign delta          = (apply_rank >= old_k) ? (apply_rank - old_k) : (old_k - apply_rank);
  assign delta_sum_next = sat_add64(delta_sum, delta);

  // The last node's delta lands on the same edge that moves the FSM into DONE.
  always_ff @(posedge clock) begin
    if (reset) begin
      delta_sum <= '0;
      converged <= 1'b0;
    end else if (start_accept) begin
      delta_sum <= '0;
      converged <= 1'b0;
    end else if (state == G_APPLY) begin
      delta_sum <= delta_sum_next;
      if (k == LAST_K) converged <= (delta_sum_next < CONV_THRESH);
    end
  end
`else
  logic unused_conv;
  assign unused_conv = ^{page_rank_old, CONV_THRESH, start_accept};
  assign converged   = 1'b0;
`endif

endmodule

// File: tb/tb_pagerank_gather.sv
// Self-checking bench for pagerank_gather: two instances (base 0 and base 4)
// share stimulus; a scoreboard queue per instance holds the expected rank stream.
module tb_pagerank_gather;
  import pagerank_pkg::*;

  localparam logic [31:0] DAMP = 32'hD999_9999;
  localparam rank_t       TELE = 64'h0000_0000_0999_9999;
  localparam rank_t       ONE  = 64'h0000_0001_0000_0000;

  typedef struct {
    node_id_t id;
    rank_t    val;
  } exp_t;

  logic          clock = 1'b0;
  logic          reset, start, contrib_valid, scatter_done;
  rank_t         contrib_value;
  node_id_t      contrib_node_id;
  rank_t [3:0]   page_rank_old;

  logic rank_valid0, gather_complete0, busy0, converged0;
  logic rank_valid4, gather_complete4, busy4, converged4;
  node_id_t rank_node_id0, rank_node_id4;
  rank_t rank_value0, rank_value4;
  logic [15:0] drop_count0, drop_count4;

  int checks = 0;
  int errors = 0;

  exp_t  exp_q0[$];
  exp_t  exp_q4[$];
  rank_t m_acc0[4];
  rank_t m_acc4[4];
  int    m_drop0, m_drop4;
  rank_t got0[4];
  rank_t got4[4];

  always #5 clock = ~clock;

  pagerank_gather #(.NODES_IN_PARTITION(4), .NODE_ID_BASE(32'd0)) dut0 (
    .clock(clock), .reset(reset), .start(start), .contrib_valid(contrib_valid),
    .contrib_value(contrib_value), .contrib_node_id(contrib_node_id),
    .scatter_done(scatter_done), .page_rank_old(page_rank_old),
    .rank_valid(rank_valid0), .rank_node_id(rank_node_id0), .rank_value(rank_value0),
    .gather_complete(gather_complete0), .busy(busy0), .drop_count(drop_count0),
    .converged(converged0)
  );

  pagerank_gather #(.NODES_IN_PARTITION(4), .NODE_ID_BASE(32'd4)) dut4 (
    .clock(clock), .reset(reset), .start(start), .contrib_valid(contrib_valid),
    .contrib_value(contrib_value), .contrib_node_id(contrib_node_id),
    .scatter_done(scatter_done), .page_rank_old(page_rank_old),
    .rank_valid(rank_valid4), .rank_node_id(rank_node_id4), .rank_value(rank_value4),
    .gather_complete(gather_complete4), .busy(busy4), .drop_count(drop_count4),
    .converged(converged4)
  );

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  function automatic rank_t model_sat(input rank_t a, input rank_t b);
    logic [64:0] s;
    s = 65'(a) + 65'(b);
    return s[64] ? 64'hFFFF_FFFF_FFFF_FFFF : s[63:0];
  endfunction

  function automatic rank_t model_rank(input rank_t a);
    logic [127:0] p;
    p = 128'(a) * 128'(DAMP);
    return model_sat(p[95:32], TELE);
  endfunction

  function automatic void model_clear();
    for (int i = 0; i < 4; i++) begin
      m_acc0[i] = '0; m_acc4[i] = '0; got0[i] = '0; got4[i] = '0;
    end
    m_drop0 = 0;
    m_drop4 = 0;
  endfunction

  function automatic void model_contrib(input node_id_t node, input rank_t value);
    node_id_t i0, i4;
    i0 = node;
    i4 = node - 32'd4;
    if (i0 < 4) m_acc0[i0[1:0]] = model_sat(m_acc0[i0[1:0]], value);
    else        m_drop0++;
    if (i4 < 4) m_acc4[i4[1:0]] = model_sat(m_acc4[i4[1:0]], value);
    else        m_drop4++;
  endfunction

  function automatic void push_expected();
    for (int i = 0; i < 4; i++) begin
      exp_q0.push_back('{id: node_id_t'(i),     val: model_rank(m_acc0[i])});
      exp_q4.push_back('{id: node_id_t'(i + 4), val: model_rank(m_acc4[i])});
    end
  endfunction

  // Scoreboard monitors pop one expected entry per emitted rank.
  always @(negedge clock) begin
    if (rank_valid0) begin
      checkOutput("sb0_pending", 64'(exp_q0.size() != 0), 64'd1);
      if (exp_q0.size() != 0) begin
        exp_t e;
        e = exp_q0.pop_front();
        checkOutput("sb0_id", 64'(rank_node_id0), 64'(e.id));
        checkOutput("sb0_val", rank_value0, e.val);
        got0[rank_node_id0[1:0]] = rank_value0;
      end
    end
  end

  always @(negedge clock) begin
    if (rank_valid4) begin
      checkOutput("sb4_pending", 64'(exp_q4.size() != 0), 64'd1);
      if (exp_q4.size() != 0) begin
        exp_t e;
        e = exp_q4.pop_front();
        checkOutput("sb4_id", 64'(rank_node_id4), 64'(e.id));
        checkOutput("sb4_val", rank_value4, e.val);
        got4[rank_node_id4[1:0]] = rank_value4;
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic applyStimulus(input bit valid, input bit done, input node_id_t node,
                               input rank_t value);
    contrib_valid   = valid;
    scatter_done    = done;
    contrib_node_id = node;
    contrib_value   = value;
    if (valid) model_contrib(node, value);
    if (done) push_expected();
    tick();
    contrib_valid = 1'b0;
    scatter_done  = 1'b0;
  endtask

  task automatic doStart();
    start = 1'b1;
    model_clear();
    tick();
    start = 1'b0;
    checkOutput("busy_after_start", 64'(busy0), 64'd1);
    checkOutput("drop_cleared", 64'(drop_count0), 64'd0);
  endtask

  task automatic waitComplete();
    bit seen = 1'b0;
    int first_v = -1;
    for (int c = 1; c <= 20 && !seen; c++) begin
      tick();
      if (rank_valid0 && first_v < 0) first_v = c;
      if (gather_complete0) begin
        seen = 1'b1;
        checkOutput("complete_latency", 64'(c), 64'd5);
        checkOutput("complete4_aligned", 64'(gather_complete4), 64'd1);
      end
    end
    checkOutput("complete_seen", 64'(seen), 64'd1);
    checkOutput("first_rank_latency", 64'(first_v), 64'd1);
    checkOutput("sb0_drained", 64'(exp_q0.size()), 64'd0);
    checkOutput("sb4_drained", 64'(exp_q4.size()), 64'd0);
    checkOutput("drop0", 64'(drop_count0), 64'(m_drop0));
    checkOutput("drop4", 64'(drop_count4), 64'(m_drop4));
    tick();
    checkOutput("complete_pulse", 64'(gather_complete0), 64'd0);
    checkOutput("idle_busy", 64'(busy0), 64'd0);
  endtask

  initial begin
    int gc_seen;
    reset = 1'b1; start = 1'b0; contrib_valid = 1'b0; scatter_done = 1'b0;
    contrib_value = '0; contrib_node_id = '0;
    for (int i = 0; i < 4; i++) page_rank_old[i] = '0;
    model_clear();
    tick(); tick();
    checkOutput("rst_rank_valid", 64'(rank_valid0), 64'd0);
    checkOutput("rst_rank_value", rank_value0, 64'd0);
    checkOutput("rst_busy", 64'(busy0), 64'd0);
    checkOutput("rst_drop", 64'(drop_count0), 64'd0);
    checkOutput("rst_complete", 64'(gather_complete0), 64'd0);
    checkOutput("rst_converged", 64'(converged0), 64'd0);
    reset = 1'b0;
    tick();

    $display("[TB] step 1: two half contributions to node 1");
    doStart();
    applyStimulus(1'b1, 1'b0, 32'd1, 64'h0000_0000_8000_0000);
    applyStimulus(1'b1, 1'b0, 32'd1, 64'h0000_0000_8000_0000);
    applyStimulus(1'b0, 1'b1, 32'd0, '0);
    waitComplete();
    checkOutput("t1_node0", got0[0], 64'h0000_0000_0999_9999);
    checkOutput("t1_node1", got0[1], 64'h0000_0000_E333_3332);
    checkOutput("t1_node3", got0[3], 64'h0000_0000_0999_9999);
    checkOutput("t1_drop4", 64'(drop_count4), 64'd2);
`ifndef PAGERANK_GATHER_CONV_EN
    checkOutput("t1_conv_off", 64'(converged0), 64'd0);
`endif

    $display("[TB] step 2: node 7 out of range for base 0, local 3 for base 4");
    doStart();
    applyStimulus(1'b1, 1'b0, 32'd7, ONE);
    checkOutput("t2_drop_inc", 64'(drop_count0), 64'd1);
    applyStimulus(1'b0, 1'b1, 32'd0, '0);
    waitComplete();
    checkOutput("t2_node3_base0", got0[3], 64'h0000_0000_0999_9999);
    checkOutput("t2_node7_base4", got4[3], 64'h0000_0000_E333_3332);

    $display("[TB] step 3: saturating accumulation");
    doStart();
    applyStimulus(1'b1, 1'b0, 32'd0, 64'hFFFF_FFFF_0000_0000);
    applyStimulus(1'b1, 1'b0, 32'd0, 64'hFFFF_FFFF_0000_0000);
    applyStimulus(1'b0, 1'b1, 32'd0, '0);
    waitComplete();
    checkOutput("t3_sat_rank", got0[0], 64'hD999_9999_0999_9998);

    $display("[TB] step 4: contribution together with scatter_done");
    doStart();
    applyStimulus(1'b1, 1'b1, 32'd2, ONE);
    waitComplete();
    checkOutput("t4_last_contrib", got0[2], 64'h0000_0000_E333_3332);

    $display("[TB] step 5: reset during APPLY");
    doStart();
    applyStimulus(1'b1, 1'b0, 32'd1, ONE);
    applyStimulus(1'b1, 1'b0, 32'd9, ONE);
    applyStimulus(1'b0, 1'b1, 32'd0, '0);
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checkOutput("t5_rank_valid", 64'(rank_valid0), 64'd0);
    checkOutput("t5_rank_id", 64'(rank_node_id0), 64'd0);
    checkOutput("t5_rank_value", rank_value0, 64'd0);
    checkOutput("t5_drop", 64'(drop_count0), 64'd0);
    checkOutput("t5_busy", 64'(busy0), 64'd0);
    exp_q0.delete();
    exp_q4.delete();
    model_clear();
    gc_seen = 0;
    for (int c = 0; c < 8; c++) begin
      tick();
      if (gather_complete0 || rank_valid0) gc_seen++;
    end
    checkOutput("t5_no_complete", 64'(gc_seen), 64'd0);
    doStart();
    applyStimulus(1'b1, 1'b0, 32'd3, ONE);
    applyStimulus(1'b0, 1'b1, 32'd0, '0);
    waitComplete();
    checkOutput("t5_clean_node1", got0[1], 64'h0000_0000_0999_9999);
    checkOutput("t5_clean_node3", got0[3], 64'h0000_0000_E333_3332);

`ifdef PAGERANK_GATHER_CONV_EN
    $display("[TB] step 6: convergence against matching and offset old ranks");
    page_rank_old[0] = 64'h0000_0000_0999_9999;
    page_rank_old[1] = 64'h0000_0000_E333_3332;
    page_rank_old[2] = 64'h0000_0000_0999_9999;
    page_rank_old[3] = 64'h0000_0000_0999_9999;
    doStart();
    applyStimulus(1'b1, 1'b0, 32'd1, ONE);
    applyStimulus(1'b0, 1'b1, 32'd0, '0);
    waitComplete();
    checkOutput("t6_converged", 64'(converged0), 64'd1);
    for (int i = 0; i < 4; i++) page_rank_old[i] = page_rank_old[i] + 64'h0000_0000_0100_0000;
    doStart();
    checkOutput("t6_cleared_on_start", 64'(converged0), 64'd0);
    applyStimulus(1'b1, 1'b0, 32'd1, ONE);
    applyStimulus(1'b0, 1'b1, 32'd0, '0);
    waitComplete();
    checkOutput("t6_not_converged", 64'(converged0), 64'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
